// File: rtl/wb_arbiter_if.sv
// Writeback bus between two result sources, the issue stage and the register file.
// Pure wiring, no latency.
// Ready/valid per source; the write strobe and pend mask have no backpressure.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int SIZE = 2**ADDR_W;

  // source 0: single-cycle ALU results
  logic              src0_valid;
  logic              src0_ready;
  logic [ADDR_W-1:0] src0_addr;
  logic [DATA_W-1:0] src0_data;

  // source 1: multi-cycle unit results
  logic              src1_valid;
  logic              src1_ready;
  logic [ADDR_W-1:0] src1_addr;
  logic [DATA_W-1:0] src1_data;

  // issue stage: destination register being claimed
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;

  // register-file write port and pending-writeback mask
  logic              wr;
  logic [ADDR_W-1:0] addr_wr;
  logic [DATA_W-1:0] data_wr;
  logic [SIZE-1:0]   pend;

  // producer side: sources, issue stage, register file
  modport master (
    output src0_valid, src0_addr, src0_data,
    output src1_valid, src1_addr, src1_data,
    output iss_valid, iss_addr,
    input  src0_ready, src1_ready,
    input  wr, addr_wr, data_wr, pend
  );

  // arbiter side
  modport slave (
    input  src0_valid, src0_addr, src0_data,
    input  src1_valid, src1_addr, src1_data,
    input  iss_valid, iss_addr,
    output src0_ready, src1_ready,
    output wr, addr_wr, data_wr, pend
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter: 2-entry FIFO per source, round-robin, register-file write port, pending mask.
// Latency: push into empty FIFO on edge E appears on wr/addr_wr/data_wr after edge E+1.
// Backpressure: srcN_ready drops when its FIFO holds 2 entries or en is low; en low freezes everything.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  wb_arbiter_if.slave     bus
);
  localparam int SIZE = 2**ADDR_W;

  // Per-source views of the bus, indexed by source number.
  logic [1:0]        in_vld;
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];

  assign in_vld     = {bus.src1_valid, bus.src0_valid};
  assign in_addr[0] = bus.src0_addr;
  assign in_addr[1] = bus.src1_addr;
  assign in_data[0] = bus.src0_data;
  assign in_data[1] = bus.src1_data;

  // FIFO storage and bookkeeping. Storage is not reset; the counts decide validity.
  logic [ADDR_W-1:0] q_addr [2][2];
  logic [DATA_W-1:0] q_data [2][2];
  logic [1:0]        wptr;
  logic [1:0]        rptr;
  logic [1:0]        cnt [2];

  // rr = source favoured on the next two-way contention (0 after reset).
  logic rr;

  logic [1:0]        rdy;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        nonempty;
  logic [ADDR_W-1:0] head_addr [2];
  logic [DATA_W-1:0] head_data [2];

  logic              gnt_any;
  logic              gnt_src;
  logic              contend;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_wr_q;
  logic [DATA_W-1:0] data_wr_q;
  logic [SIZE-1:0]   pend_q;
  logic [SIZE-1:0]   pend_nxt;

  // Ready uses only the registered count, so a full FIFO never accepts even when popping that edge.
  always_comb begin
    rdy       = '0;
    push      = '0;
    nonempty  = '0;
    for (int s = 0; s < 2; s++) begin
      rdy[s]       = rst_n & en & (cnt[s] != 2'd2);
      push[s]      = in_vld[s] & rdy[s];
      nonempty[s]  = (cnt[s] != 2'd0);
      head_addr[s] = q_addr[s][rptr[s]];
      head_data[s] = q_data[s][rptr[s]];
    end
  end

  assign bus.src0_ready = rdy[0];
  assign bus.src1_ready = rdy[1];

  // Pick at most one head per enabled cycle; round-robin only matters when both are waiting.
  always_comb begin
    gnt_any = 1'b0;
    gnt_src = 1'b0;
    contend = 1'b0;
    pop     = '0;
    if (en) begin
      if (nonempty[0] && nonempty[1]) begin
        contend = 1'b1;
        gnt_any = 1'b1;
        gnt_src = rr;
      end else if (nonempty[0]) begin
        gnt_any = 1'b1;
        gnt_src = 1'b0;
      end else if (nonempty[1]) begin
        gnt_any = 1'b1;
        gnt_src = 1'b1;
      end
    end
    if (gnt_any) begin
      pop[gnt_src] = 1'b1;
    end
    sel_addr = head_addr[gnt_src];
    sel_data = head_data[gnt_src];
  end

  // FIFO entry storage: write the slot under the write pointer on push.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        q_addr[s][wptr[s]] <= in_addr[s];
        q_data[s][wptr[s]] <= in_data[s];
      end
    end
  end

  // FIFO pointers and occupancy; reset discards anything queued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt[0] <= 2'd0;
      cnt[1] <= 2'd0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          wptr[s] <= ~wptr[s];
        end
        if (pop[s]) begin
          rptr[s] <= ~rptr[s];
        end
        case ({push[s], pop[s]})
          2'b10:   cnt[s] <= cnt[s] + 2'd1;
          2'b01:   cnt[s] <= cnt[s] - 2'd1;
          default: cnt[s] <= cnt[s];
        endcase
      end
    end
  end

  // Round-robin pointer: after a contested grant, favour the other source.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr <= 1'b0;
    end else if (contend) begin
      rr <= ~gnt_src;
    end
  end

  // Register-file write port; register 0 is popped silently and the port holds its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      addr_wr_q <= '0;
      data_wr_q <= '0;
    end else begin
      wr_q <= 1'b0;
      if (gnt_any && (sel_addr != '0)) begin
        wr_q      <= 1'b1;
        addr_wr_q <= sel_addr;
        data_wr_q <= sel_data;
      end
    end
  end

  assign bus.wr      = wr_q;
  assign bus.addr_wr = addr_wr_q;
  assign bus.data_wr = data_wr_q;

  // Pending mask: clear on writeback pop, then set on issue so a same-bit set wins; bit 0 never set.
  always_comb begin
    pend_nxt = pend_q;
    if (gnt_any && (sel_addr != '0)) begin
      pend_nxt[sel_addr] = 1'b0;
    end
    if (en && bus.iss_valid && (bus.iss_addr != '0)) begin
      pend_nxt[bus.iss_addr] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  // Pending mask register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_nxt;
    end
  end

  assign bus.pend = pend_q;

endmodule
